// File: rtl/dot_acc_pkg.sv
// ============================================================================
// Module  : dot_acc_pkg
// Purpose : Shared widths, FSM encoding and helpers for the dot-product block.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package dot_acc_pkg;

   localparam int ACC_W  = 12;
   localparam int CNT_W  = 5;
   localparam int OP_W   = 4;
   localparam int PROD_W = 8;

   typedef enum logic [1:0] {
      ST_ACCUM = 2'd0,
      ST_FLUSH = 2'd1,
      ST_DONE  = 2'd2
   } state_t;

   // Term counter sticks at all-ones instead of wrapping.
   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (v == {CNT_W{1'b1}}) ? v : v + CNT_W'(1);
   endfunction

endpackage : dot_acc_pkg

`default_nettype wire

// File: rtl/junsignedArrayMultiplier.sv
// ============================================================================
// Module  : junsignedArrayMultiplier
// Purpose : 4x4 unsigned array multiplier built from rows of ripple adders.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module junsignedArrayMultiplier
   import dot_acc_pkg::*;
(
   input  logic [OP_W-1:0]   a_i,
   input  logic [OP_W-1:0]   b_i,
   output logic [PROD_W-1:0] p_o
);

   logic [OP_W-1:0] w_pp [OP_W];
   logic [OP_W:0]   w_row1;
   logic [OP_W:0]   w_row2;
   logic [OP_W:0]   w_row3;

   // One 4-bit ripple row of full adders; returns {carry_out, sum}.
   function automatic logic [OP_W:0] fa_row(input logic [OP_W-1:0] x,
                                            input logic [OP_W-1:0] y);
      logic            c;
      logic [OP_W-1:0] s;
      c = 1'b0;
      s = '0;
      for (int k = 0; k < OP_W; k++) begin
         s[k] = x[k] ^ y[k] ^ c;
         c    = (x[k] & y[k]) | (c & (x[k] ^ y[k]));
      end
      return {c, s};
   endfunction

   generate
      for (genvar i = 0; i < OP_W; i++) begin : g_pp
         assign w_pp[i] = a_i & {OP_W{b_i[i]}};
      end
   endgenerate

   // Each row adds the next partial product to the shifted-down previous row.
   assign w_row1 = fa_row({1'b0, w_pp[0][OP_W-1:1]}, w_pp[1]);
   assign w_row2 = fa_row(w_row1[OP_W:1], w_pp[2]);
   assign w_row3 = fa_row(w_row2[OP_W:1], w_pp[3]);

   assign p_o = {w_row3, w_row2[0], w_row1[0], w_pp[0][0]};

endmodule : junsignedArrayMultiplier

`default_nettype wire

// File: rtl/dot_product_accumulator.sv
// ============================================================================
// Module  : dot_product_accumulator
// Purpose : Streams a*b terms into a 12-bit accumulator and presents the sum.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module dot_product_accumulator
   import dot_acc_pkg::*;
(
   input  logic              clk,
   input  logic              reset,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [OP_W-1:0]   a,
   input  logic [OP_W-1:0]   b,
   input  logic              in_last,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [ACC_W-1:0]  result,
   output logic [CNT_W-1:0]  count,
   output logic              ovf
);

   state_t             state_q;
   state_t             state_d;

   logic               stage_vld_q;
   logic               stage_last_q;
   logic [OP_W-1:0]    op_a_q;
   logic [OP_W-1:0]    op_b_q;

   logic [ACC_W-1:0]   acc_q;
   logic [CNT_W-1:0]   run_cnt_q;
   logic               sticky_q;

   logic [ACC_W-1:0]   result_q;
   logic [CNT_W-1:0]   count_q;
   logic               ovf_q;

   logic               w_accept;
   logic [PROD_W-1:0]  w_prod;
   logic [ACC_W:0]     w_sum;

   junsignedArrayMultiplier u_mul (
      .a_i (op_a_q),
      .b_i (op_b_q),
      .p_o (w_prod)
   );

   // Bit ACC_W of the sum is the carry-out of the 12-bit add.
   assign w_sum    = {1'b0, acc_q} + {{(ACC_W + 1 - PROD_W){1'b0}}, w_prod};
   assign w_accept = in_valid && in_ready;

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= ST_ACCUM;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      case (state_q)
         ST_ACCUM: begin
            in_ready = 1'b1;
            if (in_valid && in_last) begin
               state_d = ST_FLUSH;
            end
         end
         ST_FLUSH: begin
            state_d = ST_DONE;
         end
         ST_DONE: begin
            out_valid = 1'b1;
            if (out_ready) begin
               state_d = ST_ACCUM;
            end
         end
         default: begin
            state_d = ST_ACCUM;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         stage_vld_q  <= 1'b0;
         stage_last_q <= 1'b0;
         op_a_q       <= '0;
         op_b_q       <= '0;
      end else begin
         stage_vld_q  <= w_accept;
         stage_last_q <= w_accept && in_last;
         if (w_accept) begin
            op_a_q <= a;
            op_b_q <= b;
         end
      end
   end

   // The last term is folded in during FLUSH, straight into the output registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         acc_q     <= '0;
         run_cnt_q <= '0;
         sticky_q  <= 1'b0;
         result_q  <= '0;
         count_q   <= '0;
         ovf_q     <= 1'b0;
      end else if (state_q == ST_FLUSH) begin
         result_q  <= w_sum[ACC_W-1:0];
         count_q   <= sat_inc(run_cnt_q);
         ovf_q     <= sticky_q | w_sum[ACC_W];
         acc_q     <= '0;
         run_cnt_q <= '0;
         sticky_q  <= 1'b0;
      end else if (stage_vld_q && !stage_last_q) begin
         acc_q     <= w_sum[ACC_W-1:0];
         run_cnt_q <= sat_inc(run_cnt_q);
         sticky_q  <= sticky_q | w_sum[ACC_W];
      end
   end

   assign result = result_q;
   assign count  = count_q;
   assign ovf    = ovf_q;

endmodule : dot_product_accumulator

`default_nettype wire

// File: tb/tb_dot_product_accumulator.sv
// ============================================================================
// Module  : tb_dot_product_accumulator
// Purpose : Self-checking bench for dot_product_accumulator with a sum model.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_dot_product_accumulator;

   logic        clk = 1'b0;
   logic        reset;
   logic        in_valid;
   logic        in_ready;
   logic [3:0]  a;
   logic [3:0]  b;
   logic        in_last;
   logic        out_valid;
   logic        out_ready;
   logic [11:0] result;
   logic [4:0]  count;
   logic        ovf;

   int checks = 0;
   int errors = 0;

   int qa[$];
   int qb[$];

   dot_product_accumulator dut (
      .clk       (clk),
      .reset     (reset),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .in_last   (in_last),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .result    (result),
      .count     (count),
      .ovf       (ovf)
   );

   always #5 clk = ~clk;

   // Sends qa/qb back-to-back, checks latency and outputs, holds DONE for
   // 'hold' cycles with ignored in_valid pulses, then handshakes.
   task automatic run_dot(input string name, input int hold);
      int n;
      int total;
      int exp_res;
      int exp_cnt;
      bit exp_ovf;
      n     = qa.size();
      total = 0;
      for (int i = 0; i < n; i++) total += qa[i] * qb[i];
      exp_res = total % 4096;
      exp_cnt = (n > 31) ? 31 : n;
      exp_ovf = (total >= 4096);

      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         checks++;
         if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL %s beat%0d in_ready=%b out_valid=%b want 1/0", name, i, in_ready, out_valid);
         end
         in_valid = 1'b1;
         a        = 4'(qa[i]);
         b        = 4'(qb[i]);
         in_last  = (i == n - 1);
      end
      @(negedge clk);
      in_valid = 1'b0;
      in_last  = 1'b0;
      checks++;
      if (out_valid !== 1'b0 || in_ready !== 1'b0) begin
         errors++;
         $display("FAIL %s flush out_valid=%b in_ready=%b want 0/0", name, out_valid, in_ready);
      end
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || result !== 12'(exp_res) ||
          count !== 5'(exp_cnt) || ovf !== exp_ovf) begin
         errors++;
         $display("FAIL %s done v=%b rdy=%b res=%0d cnt=%0d ovf=%b want 1 0 %0d %0d %b",
                  name, out_valid, in_ready, result, count, ovf, exp_res, exp_cnt, exp_ovf);
      end
      for (int k = 0; k < hold; k++) begin
         in_valid  = 1'($urandom_range(0, 1));
         in_last   = 1'($urandom_range(0, 1));
         a         = 4'($urandom_range(0, 15));
         b         = 4'($urandom_range(0, 15));
         out_ready = 1'b0;
         @(negedge clk);
         checks++;
         if (out_valid !== 1'b1 || in_ready !== 1'b0 || result !== 12'(exp_res) ||
             count !== 5'(exp_cnt) || ovf !== exp_ovf) begin
            errors++;
            $display("FAIL %s hold%0d v=%b rdy=%b res=%0d cnt=%0d ovf=%b want 1 0 %0d %0d %b",
                     name, k, out_valid, in_ready, result, count, ovf, exp_res, exp_cnt, exp_ovf);
         end
      end
      in_valid  = 1'b0;
      in_last   = 1'b0;
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      checks++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0 || result !== 12'(exp_res) || count !== 5'(exp_cnt)) begin
         errors++;
         $display("FAIL %s after_hs rdy=%b v=%b res=%0d cnt=%0d want 1 0 %0d %0d",
                  name, in_ready, out_valid, result, count, exp_res, exp_cnt);
      end
   endtask

   task automatic test_reset();
      reset = 1'b1;
      repeat (3) @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      checks++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0 || result !== 12'd0 || count !== 5'd0 || ovf !== 1'b0) begin
         errors++;
         $display("FAIL reset rdy=%b v=%b res=%0d cnt=%0d ovf=%b want 1 0 0 0 0",
                  in_ready, out_valid, result, count, ovf);
      end
   endtask

   task automatic test_single_max();
      qa = '{15}; qb = '{15};
      run_dot("single_15x15", 0);
   endtask

   task automatic test_back_to_back();
      qa = '{3, 5, 7}; qb = '{4, 6, 2};
      run_dot("b2b_56", 0);
   endtask

   task automatic test_overflow();
      qa = {}; qb = {};
      for (int i = 0; i < 19; i++) begin qa.push_back(15); qb.push_back(15); end
      run_dot("ovf_19x225", 0);
      qa = '{1}; qb = '{1};
      run_dot("after_ovf_1x1", 0);
   endtask

   task automatic test_hold();
      qa = '{2}; qb = '{3};
      run_dot("hold_2x3", 5);
   endtask

   task automatic test_reset_midstream();
      @(negedge clk);
      in_valid = 1'b1; a = 4'd9; b = 4'd9; in_last = 1'b0;
      @(negedge clk);
      in_valid = 1'b0;
      reset    = 1'b1;
      @(negedge clk);
      reset    = 1'b0;
      checks++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0 || result !== 12'd0 || count !== 5'd0 || ovf !== 1'b0) begin
         errors++;
         $display("FAIL mid_reset rdy=%b v=%b res=%0d cnt=%0d ovf=%b want 1 0 0 0 0",
                  in_ready, out_valid, result, count, ovf);
      end
      qa = '{1}; qb = '{2};
      run_dot("post_reset_1x2", 0);
   endtask

   task automatic test_saturate();
      qa = {}; qb = {};
      for (int i = 0; i < 40; i++) begin qa.push_back(0); qb.push_back($urandom_range(0, 15)); end
      run_dot("sat_40_zero", 0);
   endtask

   task automatic test_random();
      for (int t = 0; t < 8; t++) begin
         int n;
         n  = $urandom_range(1, 40);
         qa = {}; qb = {};
         for (int i = 0; i < n; i++) begin
            qa.push_back($urandom_range(0, 15));
            qb.push_back($urandom_range(0, 15));
         end
         run_dot($sformatf("rand%0d_n%0d", t, n), $urandom_range(0, 3));
      end
   endtask

   initial begin
      reset     = 1'b1;
      in_valid  = 1'b0;
      in_last   = 1'b0;
      a         = 4'd0;
      b         = 4'd0;
      out_ready = 1'b0;
      test_reset();
      test_single_max();
      test_back_to_back();
      test_overflow();
      test_hold();
      test_reset_midstream();
      test_saturate();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule : tb_dot_product_accumulator

`default_nettype wire

// File: doc/dot_product_accumulator.md
DOT_PRODUCT_ACCUMULATOR -- requirements
Module: dot_product_accumulator

Interface
REQ-001 Parameters: none; all widths are fixed constants from the shared package (REQ-027).
REQ-002 The block SHALL use one clock; reset is synchronous and active-high.
REQ-003 clk  input  1  rising-edge clock for all state.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 in_valid  input  1  operand pair a/b is presented this cycle.
REQ-006 in_ready  output  1  block accepts an operand pair this cycle.
REQ-007 a  input  4  unsigned multiplicand.
REQ-008 b  input  4  unsigned multiplier.
REQ-009 in_last  input  1  the presented pair is the final term of the current dot product.
REQ-010 out_valid  output  1  result, count and ovf are valid.
REQ-011 out_ready  input  1  consumer takes the result this cycle.
REQ-012 result  output  12  sum of a*b over all terms, modulo 4096.
REQ-013 count  output  5  number of terms in the result, saturating at 31.
REQ-014 ovf  output  1  one or more 12-bit accumulator additions carried out.

Function
REQ-015 Accept: an input beat SHALL be accepted when in_valid && in_ready. a, b and in_last are registered into an operand stage with a stage-valid bit.
REQ-016 The product SHALL be the 8-bit unsigned product of the registered operands, taken combinationally from the operand stage.
REQ-017 The FSM SHALL have three states:
  - ACCUM: in_ready=1, out_valid=0.
  - FLUSH: in_ready=0, out_valid=0.
  - DONE: in_ready=0, out_valid=1.
REQ-018 In ACCUM, an accepted beat with in_last=1 SHALL move the FSM to FLUSH. Any other accepted beat, or no beat, SHALL leave the FSM in ACCUM.
REQ-019 FLUSH SHALL last exactly one cycle, then move to DONE.
REQ-020 Entering DONE SHALL load the following, and SHALL clear acc, the running count and the sticky ovf source:
  - result = acc + product;
  - count = running count + 1 (saturating at 31);
  - ovf = sticky carry OR the carry of this final add.
REQ-021 Each cycle the stage holds a valid non-last term, the block SHALL do acc <= acc + zero-extended product (12-bit, wraps), increment count (saturating at 31), and OR the carry-out into the sticky ovf.
REQ-022 Latency: the last beat accepted in cycle t SHALL produce out_valid=1 in cycle t+2. Back-to-back beats SHALL sustain one term per cycle.
REQ-023 DONE SHALL hold result, count and ovf stable while out_ready=0. out_valid && out_ready SHALL return the FSM to ACCUM on the next cycle, with in_ready=1 in that cycle.
REQ-024 A zero product SHALL still count as a term. in_valid while in_ready=0 SHALL be ignored, with no state change.
REQ-025 result, count and ovf SHALL be undefined-free: they hold their last loaded value outside DONE and are 0 after reset.

Reset
REQ-026 While reset=1 at a clock edge, regardless of state or in-flight terms, the block SHALL set:
  - FSM = ACCUM;
  - stage-valid = 0, acc = 0, running count = 0, sticky ovf = 0;
  - result = 0, count = 0, ovf = 0, out_valid = 0.
  in_ready SHALL read 1 in the first cycle after reset deasserts. A partial dot product interrupted by reset is discarded.

Structure
REQ-027 A shared package dot_acc_pkg SHALL hold:
  - ACC_W=12, CNT_W=5, OP_W=4, PROD_W=8;
  - the FSM state encoding ST_ACCUM=2'd0, ST_FLUSH=2'd1, ST_DONE=2'd2.
REQ-028 The multiply SHALL be one instance of the team's existing 4x4 unsigned array multiplier (junsignedArrayMultiplier). There is no other sub-module; the adder and counters are local RTL.

Verification
REQ-029 Single beat a=15, b=15, last=1 at cycle t -> out_valid at t+2; result=225, count=1, ovf=0.
REQ-030 Beats 3*4, 5*6, 7*2 (last on the third), back-to-back -> result=56, count=3, ovf=0; in_ready=0 from the cycle after the last beat until the handshake.
REQ-031 19 beats of 15*15, last on the 19th -> result=179 (4275 mod 4096), count=19, ovf=1. The next dot product 1*1 last -> result=1, ovf=0.
REQ-032 Single beat 2*3 last, then out_ready held 0 for 5 cycles -> result=6 stable, out_valid=1, in_ready=0 throughout; in_valid pulses are ignored. The handshake in the 6th cycle returns in_ready=1 next cycle.
REQ-033 Reset asserted one cycle after accepting 9*9 (non-last) -> all outputs 0. A following 1*2 last -> result=2, count=1.
REQ-034 40 beats of 0*x, last on the 40th -> result=0, count=31 (saturated), ovf=0.
